// File: rtl/shifter_pkg.sv
// Shared types and sizing constants for the pipelined right shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SRL = 2'd0,
    SRA = 2'd1,
    ROR = 2'd2
  } shift_op_t;

  localparam int unsigned SHIFTER_WIDTH   = 64;
  localparam int unsigned SHIFTER_SHAMT_W = 6;
  localparam int unsigned SHIFTER_RANKS   = 3;

endpackage

// File: rtl/stage_lr.sv
// One fixed-distance right-shift stage of the shifter cascade (combinational).
// Rotate wrap path exists only when LR_SHIFTER_ROTATE_EN is defined;
// otherwise ROR and the reserved op code shift with zero fill.
module stage_lr
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFTER_WIDTH,
  parameter int unsigned SHAMT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] shifted
);

  // Shift by SHAMT when enabled; the MSB of the partial result is still the
  // original sign bit, so arithmetic fill cascades correctly across stages.
  always_comb begin
    shifted = data;
    if (enable) begin
      case (op)
        SRA:     shifted = {{SHAMT{data[WIDTH-1]}}, data[WIDTH-1:SHAMT]};
`ifdef LR_SHIFTER_ROTATE_EN
        ROR:     shifted = {data[SHAMT-1:0], data[WIDTH-1:SHAMT]};
`endif
        default: shifted = {{SHAMT{1'b0}}, data[WIDTH-1:SHAMT]};
      endcase
    end
  end

endmodule

// File: rtl/lr_shifter_pipe.sv
// Pipelined logical/arithmetic/rotate right shifter with valid/ready handshake.
// Log-shifter cascade, one register rank after every second stage.
// Optional feature macro: LR_SHIFTER_ROTATE_EN (enables ROR).
module lr_shifter_pipe
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH   = SHIFTER_WIDTH,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int unsigned RANKS = (SHAMT_W + 1) / 2;

  logic                 adv;
  shift_op_t            op_in;

  logic [RANKS-1:0]     rank_valid;
  logic [WIDTH-1:0]     rank_data  [RANKS];
  logic [SHAMT_W-1:0]   rank_shamt [RANKS];
  shift_op_t            rank_op    [RANKS];
  logic [WIDTH-1:0]     rank_next  [RANKS];

  logic [WIDTH-1:0]     stage_in   [SHAMT_W];
  logic [WIDTH-1:0]     stage_out  [SHAMT_W];
  logic [SHAMT_W-1:0]   stage_en;
  shift_op_t            stage_op   [SHAMT_W];

  assign op_in     = shift_op_t'(in_op);
  assign out_valid = rank_valid[RANKS-1];
  assign out_data  = rank_data[RANKS-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // Stage s lives in rank s/2: even stages start from the previous rank's
  // registers (or the input port), odd stages chain off their even partner.
  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    if (s % 2 == 0) begin : g_head
      if (s == 0) begin : g_port
        assign stage_in[s] = in_data;
        assign stage_en[s] = in_shamt[s];
        assign stage_op[s] = op_in;
      end else begin : g_reg
        assign stage_in[s] = rank_data[s/2-1];
        assign stage_en[s] = rank_shamt[s/2-1][s];
        assign stage_op[s] = rank_op[s/2-1];
      end
    end else begin : g_tail
      assign stage_in[s] = stage_out[s-1];
      assign stage_op[s] = stage_op[s-1];
      if (s < 2) begin : g_port
        assign stage_en[s] = in_shamt[s];
      end else begin : g_reg
        assign stage_en[s] = rank_shamt[s/2-1][s];
      end
    end

    stage_lr #(
      .WIDTH (WIDTH),
      .SHAMT (1 << s)
    ) u_stage (
      .data    (stage_in[s]),
      .enable  (stage_en[s]),
      .op      (stage_op[s]),
      .shifted (stage_out[s])
    );
  end

  for (genvar r = 0; r < RANKS; r++) begin : g_next
    assign rank_next[r] = stage_out[(2*r+1 < SHAMT_W) ? 2*r+1 : SHAMT_W-1];
  end

  // Rank registers: all ranks advance together on adv, empty ranks pass bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rank_valid <= '0;
      for (int unsigned r = 0; r < RANKS; r++) begin
        rank_data[r]  <= '0;
        rank_shamt[r] <= '0;
        rank_op[r]    <= SRL;
      end
    end else if (adv) begin
      rank_valid[0] <= in_valid;
      rank_data[0]  <= rank_next[0];
      rank_shamt[0] <= in_shamt;
      rank_op[0]    <= op_in;
      for (int unsigned r = 1; r < RANKS; r++) begin
        rank_valid[r] <= rank_valid[r-1];
        rank_data[r]  <= rank_next[r];
        rank_shamt[r] <= rank_shamt[r-1];
        rank_op[r]    <= rank_op[r-1];
      end
    end
  end

endmodule

// File: tb/tb_lr_shifter_pipe.sv
// Scoreboard bench for lr_shifter_pipe (64-bit default build).
// Honours LR_SHIFTER_ROTATE_EN when computing ROR expectations.
module tb_lr_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  lr_shifter_pipe #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned pops     = 0;
  logic [63:0] last_out = '0;
  int unsigned last_lat = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] sh,
                                            input logic [1:0] op);
    case (op)
      2'd1: return $signed(d) >>> sh;
      2'd2: begin
`ifdef LR_SHIFTER_ROTATE_EN
        return (d >> sh) | (d << (7'd64 - {1'b0, sh}));
`else
        return d >> sh;
`endif
      end
      default: return d >> sh;
    endcase
  endfunction

  // Called at a negedge after inputs are driven; records the handshakes of
  // the coming posedge and returns at the following negedge.
  task automatic step(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (!rst) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_data", out_data, e.data);
          last_out = out_data;
          last_lat = cyc - e.cyc;
          pops++;
        end
      end
      if (acc) sb.push_back('{data: ref_shift(in_data, in_shamt, in_op), cyc: cyc});
    end else begin
      sb.delete();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step(acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 3; i++) step(acc);
  endtask

  task automatic send_one(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] op,
                          input string tag, input logic [63:0] exp);
    bit acc;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_op     = op;
    out_ready = 1'b1;
    step(acc);
    check("accept", 64'(acc), 64'd1);
    drain();
    check(tag, last_out, exp);
  endtask

  initial begin
    bit          acc;
    logic [63:0] snap;
    int unsigned sent;
    int unsigned pops_before;
    int unsigned n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = 2'd0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) step(acc);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b0;

    // Directed vectors; the first is accepted right after reset
    send_one(64'h8000_0000_0000_0001, 6'd1, 2'd0, "srl_1", 64'h4000_0000_0000_0000);
    check("latency", 64'(last_lat), 64'd3);
    send_one(64'hF000_0000_0000_0000, 6'd4, 2'd1, "sra_4", 64'hFF00_0000_0000_0000);
    send_one(64'hF000_0000_0000_0000, 6'd4, 2'd0, "srl_4", 64'h0F00_0000_0000_0000);
`ifdef LR_SHIFTER_ROTATE_EN
    send_one(64'h0000_0000_0000_00FF, 6'd8, 2'd2, "ror_8", 64'hFF00_0000_0000_0000);
`else
    send_one(64'h0000_0000_0000_00FF, 6'd8, 2'd2, "ror_8", 64'h0000_0000_0000_0000);
`endif
    send_one(64'hF000_0000_0000_0000, 6'd4, 2'd3, "rsvd_op", 64'h0F00_0000_0000_0000);
    send_one(64'h8000_0000_0000_0000, 6'd63, 2'd1, "sra_63", 64'hFFFF_FFFF_FFFF_FFFF);
    send_one(64'h8000_0000_0000_0000, 6'd63, 2'd0, "srl_63", 64'h0000_0000_0000_0001);
    send_one(64'hA5C3_1234_DEAD_BEEF, 6'd0, 2'd0, "zero_srl", 64'hA5C3_1234_DEAD_BEEF);
    send_one(64'hA5C3_1234_DEAD_BEEF, 6'd0, 2'd1, "zero_sra", 64'hA5C3_1234_DEAD_BEEF);
    send_one(64'hA5C3_1234_DEAD_BEEF, 6'd0, 2'd2, "zero_ror", 64'hA5C3_1234_DEAD_BEEF);

    // Backpressure: 5 requests, consumer stalled
    pops_before = pops;
    out_ready   = 1'b0;
    sent        = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h1111_0000_0000_0000 * 64'(sent + 1);
      in_shamt = 6'(sent * 3);
      in_op    = 2'(sent);
      step(acc);
      check("bp_accept", 64'(acc), 64'd1);
      if (acc) sent++;
    end
    in_data  = 64'h1111_0000_0000_0000 * 64'(sent + 1);
    in_shamt = 6'(sent * 3);
    in_op    = 2'(sent);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    snap = out_data;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      check("bp_no_accept", 64'(acc), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data", out_data, snap);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sent < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h1111_0000_0000_0000 * 64'(sent + 1);
      in_shamt = 6'(sent * 3);
      in_op    = 2'(sent);
      step(acc);
      if (acc) sent++;
    end
    check("bp_sent", 64'(sent), 64'd5);
    drain();
    check("bp_results", 64'(pops - pops_before), 64'd5);

    // Reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hDEAD_0000_0000_0000 + 64'(i);
      in_shamt = 6'(i);
      in_op    = 2'd0;
      step(acc);
    end
    pops_before = pops;
    rst      = 1'b1;
    in_valid = 1'b0;
    step(acc);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_flush_valid", 64'(out_valid), 64'd0);
      step(acc);
    end
    drain();
    check("rst_no_stale", 64'(pops - pops_before), 64'd0);

    // Random sweep against the reference model
    n = 0;
    for (int i = 0; i < 40000 && n < 10000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = {$urandom, $urandom};
      case ($urandom_range(0, 15))
        0:       in_shamt = 6'd0;
        1:       in_shamt = 6'd63;
        default: in_shamt = 6'($urandom_range(0, 63));
      endcase
      in_op     = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) n++;
    end
    check("sweep_count", 64'(n), 64'd10000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
